// File: rtl/hwjsoc_loader_pkg.sv
// Shared types and defaults for the instruction memory loader.
// Holds the loader state encoding and bus width defaults.
package hwjsoc_loader_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_READ,
    S_COMPARE,
    S_FINISH
  } state_t;

endpackage

// File: rtl/hwjsoc_byte_packer.sv
// Little-endian byte to 32-bit word packer.
// word is complete (combinationally) while word_valid pulses.
module hwjsoc_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        in_valid,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] lo;

  // Store the first three bytes; the fourth passes straight through.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane <= 2'd0;
      lo   <= 24'd0;
    end else if (in_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    lo[7:0]   <= data;
        2'd1:    lo[15:8]  <= data;
        2'd2:    lo[23:16] <= data;
        default: ;
      endcase
    end
  end

  assign word       = {data, lo};
  assign word_valid = in_valid && (lane == 2'd3);

endmodule

// File: rtl/hwjsoc_inst_mem_loader.sv
// Streams bytes into an Avalon-MM instruction memory, or
// verifies memory contents against the stream.
module hwjsoc_inst_mem_loader
  import hwjsoc_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              cmd_verify,
  input  logic [7:0]        st_data,
  input  logic              st_valid,
  output logic              st_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  logic mem_clken;
  logic mem_reset_req;
  logic rst;

  assign mem_clken     = 1'b1;
  assign mem_reset_req = 1'b0;
  assign rst           = reset | mem_reset_req;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  count;
  logic              verify;
  logic [DATA_W-1:0] cmp_word;
  logic [31:0]       pk_word;
  logic              pk_valid;
  logic              last;
  logic              accept;
  logic              cs_raw;
  logic              wr_raw;

  assign accept = cmd_valid & cmd_ready;
  assign last   = (count == CNT_W'(1));

  hwjsoc_byte_packer u_packer (
    .clk        (clk),
    .reset      (rst),
    .data       (st_data),
    .in_valid   (st_valid & st_ready),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    st_ready  = 1'b0;
    done      = 1'b0;
    cs_raw    = 1'b0;
    wr_raw    = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_nx = (cmd_count == '0) ? S_FINISH : S_COLLECT;
      end
      S_COLLECT: begin
        st_ready = 1'b1;
        if (pk_valid)
          state_nx = verify ? S_READ : S_WRITE;
      end
      S_WRITE: begin
        cs_raw   = 1'b1;
        wr_raw   = 1'b1;
        state_nx = last ? S_FINISH : S_COLLECT;
      end
      S_READ: begin
        cs_raw   = 1'b1;
        state_nx = S_COMPARE;
      end
      S_COMPARE: state_nx = last ? S_FINISH : S_COLLECT;
      S_FINISH: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign m_chipselect = cs_raw & mem_clken;
  assign m_write      = wr_raw & mem_clken;
  assign m_byteenable = m_chipselect ? 4'hF : 4'h0;
  assign busy         = (state != S_IDLE);

  // Command, address/data latches and sticky verify error.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr        <= '0;
      count       <= '0;
      verify      <= 1'b0;
      cmp_word    <= '0;
      m_address   <= '0;
      m_writedata <= '0;
      err         <= 1'b0;
      err_addr    <= '0;
    end else begin
      if (accept) begin
        addr     <= cmd_addr;
        count    <= cmd_count;
        verify   <= cmd_verify;
        err      <= 1'b0;
        err_addr <= '0;
      end
      if (pk_valid) begin
        m_address <= addr;
        cmp_word  <= pk_word;
        if (!verify) m_writedata <= pk_word;
      end
      if (state == S_COMPARE && m_readdata != cmp_word && !err) begin
        err      <= 1'b1;
        err_addr <= addr;
      end
      if (state == S_WRITE || state == S_COMPARE) begin
        addr  <= addr + ADDR_W'(1);
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hwjsoc_inst_mem_loader.sv
// Directed self-checking bench for hwjsoc_inst_mem_loader.
// Uses a 1-cycle-latency memory model on the Avalon-MM side.
module tb_hwjsoc_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [12:0] cmd_addr;
  logic [13:0] cmd_count;
  logic        cmd_verify;
  logic [7:0]  st_data;
  logic        st_valid;
  logic        st_ready;
  logic [12:0] m_address;
  logic        m_chipselect;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [12:0] err_addr;

  always #5 clk = ~clk;

  hwjsoc_inst_mem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_count    (cmd_count),
    .cmd_verify   (cmd_verify),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_addr     (err_addr)
  );

  logic [31:0] mem [0:8191];
  int cyc = 0, acc_cyc = 0, done_cyc = 0;
  int acc_cnt = 0, wr_cnt = 0, be_bad = 0;
  int checks = 0, fails = 0;

  // Memory model plus access and latency bookkeeping.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
    if (done) done_cyc <= cyc;
    if (m_chipselect) begin
      acc_cnt <= acc_cnt + 1;
      if (m_byteenable != 4'hF) be_bad <= be_bad + 1;
      if (m_write) begin
        mem[m_address] <= m_writedata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        m_readdata <= mem[m_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [12:0] a, input logic [13:0] n,
                       input logic v);
    logic ok;
    int k;
    cmd_addr   = a;
    cmd_count  = n;
    cmd_verify = v;
    cmd_valid  = 1'b1;
    ok = 1'b0;
    for (k = 0; k < 50 && !ok; k++) begin
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int k;
    st_data  = b;
    st_valid = 1'b1;
    ok = 1'b0;
    for (k = 0; k < 50 && !ok; k++) begin
      ok = st_ready;
      tick();
    end
    st_valid = 1'b0;
    if (!ok) chk("byte_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) tick();
      send_byte(w[i*8 +: 8]);
    end
  endtask

  task automatic wait_done();
    logic ok;
    int k;
    ok = 1'b0;
    for (k = 0; k < 200 && !ok; k++) begin
      if (done) ok = 1'b1;
      else tick();
    end
    if (!ok) chk("done_timeout", 0, 1);
    else tick();
  endtask

  int w0, a0;

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_count  = '0;
    cmd_verify = 1'b0;
    st_data    = '0;
    st_valid   = 1'b0;
    m_readdata = '0;
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_st_ready", st_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_m_cs", m_chipselect, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_be", m_byteenable, 0);
    chk("rst_m_addr", m_address, 0);
    chk("rst_m_wdata", m_writedata, 0);
    reset = 1'b0;
    tick();

    // Program two words at 0x010.
    w0 = wr_cnt;
    issue(13'h010, 14'd2, 1'b0);
    chk("prog_busy", busy, 1);
    send_word(32'h44332211, 0);
    chk("prog_m_write", m_write, 1);
    chk("prog_m_addr0", m_address, 13'h010);
    chk("prog_m_wdata0", m_writedata, 32'h44332211);
    send_word(32'h88776655, 0);
    wait_done();
    chk("prog_mem0", mem[13'h010], 32'h44332211);
    chk("prog_mem1", mem[13'h011], 32'h88776655);
    chk("prog_wr_cnt", wr_cnt - w0, 2);
    chk("prog_latency", done_cyc - acc_cyc, 11);
    chk("prog_idle_busy", busy, 0);
    chk("prog_idle_cs", m_chipselect, 0);
    chk("prog_hold_wdata", m_writedata, 32'h88776655);
    chk("prog_hold_addr", m_address, 13'h011);

    // Verify the same region.
    w0 = wr_cnt;
    issue(13'h010, 14'd2, 1'b1);
    send_word(32'h44332211, 0);
    send_word(32'h88776655, 0);
    wait_done();
    chk("ver_err", err, 0);
    chk("ver_no_write", wr_cnt - w0, 0);
    chk("ver_latency", done_cyc - acc_cyc, 13);

    // Seed 0x012, then verify three words with two mismatches.
    issue(13'h012, 14'd1, 1'b0);
    send_word(32'hAABBCCDD, 0);
    wait_done();
    issue(13'h010, 14'd3, 1'b1);
    send_word(32'h44332211, 0);
    send_word(32'h88006655, 0);
    send_word(32'h00000000, 0);
    wait_done();
    chk("mis_err", err, 1);
    chk("mis_err_addr", err_addr, 13'h011);
    repeat (3) tick();
    chk("mis_err_hold", err, 1);
    chk("mis_err_addr_hold", err_addr, 13'h011);

    // Wrap from 0x1FFF to 0x0000; accept clears the error.
    w0 = wr_cnt;
    issue(13'h1FFF, 14'd2, 1'b0);
    chk("wrap_err_clr", err, 0);
    chk("wrap_err_addr_clr", err_addr, 0);
    send_word(32'h04030201, 0);
    send_word(32'h08070605, 0);
    wait_done();
    chk("wrap_mem_top", mem[13'h1FFF], 32'h04030201);
    chk("wrap_mem_zero", mem[13'h0000], 32'h08070605);
    chk("wrap_wr_cnt", wr_cnt - w0, 2);
    chk("wrap_last_addr", m_address, 13'h0000);

    // Zero-length command.
    a0 = acc_cnt;
    issue(13'h055, 14'd0, 1'b0);
    chk("zero_done", done, 1);
    wait_done();
    chk("zero_latency", done_cyc - acc_cyc, 1);
    chk("zero_no_access", acc_cnt - a0, 0);

    // Stream with random stalls.
    w0 = wr_cnt;
    issue(13'h100, 14'd2, 1'b0);
    send_word(32'hDEADBEEF, 3);
    send_word(32'h0BADF00D, 3);
    wait_done();
    chk("gap_mem0", mem[13'h100], 32'hDEADBEEF);
    chk("gap_mem1", mem[13'h101], 32'h0BADF00D);
    chk("gap_wr_cnt", wr_cnt - w0, 2);
    checks++;
    assert (done_cyc - acc_cyc >= 11) else begin
      fails++;
      $error("FAIL gap_latency: got %0d expected >= 11",
             done_cyc - acc_cyc);
    end

    // Reset after two bytes of a word.
    a0 = acc_cnt;
    issue(13'h200, 14'd1, 1'b0);
    send_byte(8'h99);
    send_byte(8'h98);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_st_ready", st_ready, 0);
    tick();
    chk("mid_rst_no_access", acc_cnt - a0, 0);
    chk("mid_rst_cs", m_chipselect, 0);
    issue(13'h200, 14'd1, 1'b0);
    send_word(32'hD4C3B2A1, 0);
    wait_done();
    chk("mid_rst_mem", mem[13'h200], 32'hD4C3B2A1);
    chk("mid_rst_wr_cnt", acc_cnt - a0, 1);
    chk("byteenable_all", be_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
